// File: rtl/sobel_window_gen.sv
// sobel_window_gen: 3x3 sliding-window generator for a raster pixel stream.
// Ports:
//   clk, rst (async active-low)
//   pix_in[7:0], pix_valid, sof    raster input, no backpressure
//   p00..p22[7:0]                  registered window (row 0 = oldest line, col 0 = leftmost)
//   win_valid                      window holds a complete in-image neighbourhood
//   frame_done                     pulse after the last pixel of a frame is accepted
module sobel_window_gen #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] pix_in,
    input  logic       pix_valid,
    input  logic       sof,
    output logic [7:0] p00,
    output logic [7:0] p01,
    output logic [7:0] p02,
    output logic [7:0] p10,
    output logic [7:0] p11,
    output logic [7:0] p12,
    output logic [7:0] p20,
    output logic [7:0] p21,
    output logic [7:0] p22,
    output logic       win_valid,
    output logic       frame_done
);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    logic [CW-1:0]       r_col, w_col, w_col_nxt;
    logic [RW-1:0]       r_row, w_row, w_row_nxt;
    logic                w_col_last, w_row_last;
    logic [7:0]          w_lb1, w_lb2;
    logic [7:0]          r_lb1 [IMG_WIDTH];
    logic [7:0]          r_lb2 [IMG_WIDTH];
    logic [2:0][2:0][7:0] r_win;
    logic                r_win_valid, r_frame_done;

    // sof forces the current pixel to (0,0) regardless of the counters
    always_comb begin
        w_col      = sof ? '0 : r_col;
        w_row      = sof ? '0 : r_row;
        w_col_last = (w_col == CW'(IMG_WIDTH - 1));
        w_row_last = (w_row == RW'(IMG_HEIGHT - 1));
        w_col_nxt  = w_col_last ? '0 : w_col + CW'(1);
        w_row_nxt  = w_col_last ? (w_row_last ? '0 : w_row + RW'(1)) : w_row;
        w_lb1      = r_lb1[w_col];
        w_lb2      = r_lb2[w_col];
    end

    // line buffers carry no reset; the valid gating hides stale contents
    always_ff @(posedge clk) begin
        if (pix_valid) begin
            r_lb2[w_col] <= w_lb1;
            r_lb1[w_col] <= pix_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_col        <= '0;
            r_row        <= '0;
            r_win        <= '0;
            r_win_valid  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_win_valid  <= pix_valid && (w_col >= CW'(2)) && (w_row >= RW'(2));
            r_frame_done <= pix_valid && w_col_last && w_row_last;
            if (pix_valid) begin
                r_col <= w_col_nxt;
                r_row <= w_row_nxt;
                for (int i = 0; i < 3; i++) begin
                    r_win[i][0] <= r_win[i][1];
                    r_win[i][1] <= r_win[i][2];
                end
                r_win[0][2] <= w_lb2;
                r_win[1][2] <= w_lb1;
                r_win[2][2] <= pix_in;
            end
        end
    end

    assign p00        = r_win[0][0];
    assign p01        = r_win[0][1];
    assign p02        = r_win[0][2];
    assign p10        = r_win[1][0];
    assign p11        = r_win[1][1];
    assign p12        = r_win[1][2];
    assign p20        = r_win[2][0];
    assign p21        = r_win[2][1];
    assign p22        = r_win[2][2];
    assign win_valid  = r_win_valid;
    assign frame_done = r_frame_done;
endmodule

// File: tb/tb_sobel_window_gen.sv
// tb_sobel_window_gen: scoreboard bench for sobel_window_gen on a 5x4 image.
module tb_sobel_window_gen;
    localparam int W = 5;
    localparam int H = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] pix_in = '0;
    logic       pix_valid = 1'b0;
    logic       sof = 1'b0;
    logic [7:0] p00, p01, p02, p10, p11, p12, p20, p21, p22;
    logic       win_valid, frame_done;

    sobel_window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid), .sof(sof),
        .p00(p00), .p01(p01), .p02(p02), .p10(p10), .p11(p11), .p12(p12),
        .p20(p20), .p21(p21), .p22(p22), .win_valid(win_valid), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int          n_win = 0;
    int          fd_cnt = 0;
    bit          alt = 0;
    logic [72:0] q[$];
    logic [71:0] first_win, last_win, prev_win;
    logic        prev_wv = 1'b0;
    logic [7:0]  img [H][W];
    int          mr = 0;
    int          mc = 0;

    localparam logic [71:0] FIRST_WIN = 72'h00_01_02_0a_0b_0c_14_15_16;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [71:0] cur_win();
        return {p00, p01, p02, p10, p11, p12, p20, p21, p22};
    endfunction

    // monitor: pops the expected window whenever the DUT flags one
    always @(posedge clk) begin
        logic [72:0] e;
        logic [71:0] cur;
        #1;
        cur = cur_win();
        if (win_valid === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_window: got %0h expected none", cur);
            end else begin
                e = q.pop_front();
                chk("window", cur, e[71:0]);
                chk("frame_done_with_window", {71'b0, frame_done}, {71'b0, e[72]});
            end
            if (alt) chk("no_consecutive_win_valid", {71'b0, prev_wv}, 72'b0);
            if (n_win == 0) first_win = cur;
            last_win = cur;
            n_win++;
        end else if (frame_done === 1'b1) begin
            chk("frame_done_without_window", {71'b0, frame_done}, 72'b0);
        end
        if (frame_done === 1'b1) fd_cnt++;
        if (alt && !pix_valid) chk("hold_in_gap", cur, prev_win);
        prev_win = cur;
        prev_wv  = win_valid;
    end

    task automatic send(input logic [7:0] v, input logic s);
        logic [71:0] w;
        @(negedge clk);
        pix_in = v;
        pix_valid = 1'b1;
        sof = s;
        if (s) begin
            mr = 0;
            mc = 0;
        end
        img[mr][mc] = v;
        if (mr >= 2 && mc >= 2) begin
            w = '0;
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    w = {w[63:0], img[mr-2+i][mc-2+j]};
            q.push_back({(mr == H-1 && mc == W-1), w});
        end
        if (mc == W-1) begin
            mc = 0;
            mr = (mr == H-1) ? 0 : mr + 1;
        end else mc++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            pix_valid = 1'b0;
            sof = 1'b0;
        end
    endtask

    task automatic send_frame(input bit with_sof, input bit gaps);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                send(8'(10*r + c), with_sof && r == 0 && c == 0);
                if (gaps) idle(1);
            end
    endtask

    task automatic start_test();
        n_win = 0;
        fd_cnt = 0;
    endtask

    task automatic end_test(input string name, input int exp_win, input int exp_fd);
        idle(3);
        chk({name, "_window_count"}, 72'(n_win), 72'(exp_win));
        chk({name, "_frame_done_count"}, 72'(fd_cnt), 72'(exp_fd));
        chk({name, "_queue_drained"}, 72'(q.size()), 72'(0));
    endtask

    initial begin
        // asynchronous reset from power-up, asserted between edges
        #7 rst = 1'b0;
        #1;
        chk("reset_window", cur_win(), 72'b0);
        chk("reset_win_valid", {71'b0, win_valid}, 72'b0);
        chk("reset_frame_done", {71'b0, frame_done}, 72'b0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #2;
        chk("post_reset_window", cur_win(), 72'b0);
        chk("post_reset_win_valid", {71'b0, win_valid}, 72'b0);

        // continuous frame
        start_test();
        send_frame(1, 0);
        end_test("continuous", 6, 1);
        chk("continuous_first", first_win, FIRST_WIN);
        chk("continuous_last_p22", {64'b0, last_win[7:0]}, 72'd34);
        chk("continuous_last_p00", {64'b0, last_win[71:64]}, 72'd12);

        // alternating pix_valid
        start_test();
        alt = 1;
        send_frame(1, 1);
        end_test("alternating", 6, 1);
        alt = 0;
        chk("alternating_first", first_win, FIRST_WIN);

        // two back-to-back frames
        start_test();
        send_frame(1, 0);
        send_frame(1, 0);
        end_test("back_to_back", 12, 2);
        chk("back_to_back_last_p22", {64'b0, last_win[7:0]}, 72'd34);

        // sof on the 8th accepted pixel restarts the frame there
        start_test();
        for (int c = 0; c < W; c++) send(8'(c), c == 0);
        send(8'd10, 0);
        send(8'd11, 0);
        send(8'd12, 1);
        for (int k = 0; k < W*H - 1; k++) send(8'(100 + k), 0);
        end_test("mid_sof", 6, 1);
        chk("mid_sof_first_p00", {64'b0, first_win[71:64]}, 72'd12);

        // async reset while pixel (2,3) is presented
        start_test();
        for (int k = 0; k < 2*W + 3; k++) send(8'(10*(k / W) + (k % W)), k == 0);
        @(negedge clk);
        pix_in = 8'd23;
        pix_valid = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("midframe_reset_window", cur_win(), 72'b0);
        chk("midframe_reset_win_valid", {71'b0, win_valid}, 72'b0);
        q.delete();
        mr = 0;
        mc = 0;
        start_test();
        @(negedge clk);
        pix_valid = 1'b0;
        rst = 1'b1;
        send_frame(0, 0);
        end_test("after_reset", 6, 1);
        chk("after_reset_first", first_win, FIRST_WIN);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
